disp_spi_cmd_decoder: RTL and testbench
=======================================

Name: disp_spi_cmd_decoder

Overview:
Sits directly downstream of the SPI slave and upstream of the 6-digit hex multiplexer. Parses framed byte strobes into a 6-entry digit register file (4-bit hex value plus decimal point per digit) and drives the multiplexer's digit/dp inputs. Supplies readback bytes to the SPI slave's transmit path. Replaces the ad-hoc two-byte parser with a framed, error-checked state machine that supports bulk writes and reads.

Parameters:
NUM_DIGITS, 6, number of digit registers; valid index range is 0..NUM_DIGITS-1.
ID_BYTE, 8'hA5, byte returned on tx_data while idle or after an errored command.
RESET_HEX, 4'h0, reset value of every digit nibble.

Ports:
CLK_12_MHZ  in  1  system clock, 12 MHz.
rst_n  in  1  synchronous reset, active-low.
ssel  in  1  SPI chip select, active-low, already synchronised by the SPI slave; a high level ends the frame.
byte_rx  in  1  one-cycle strobe; rx_data is valid.
rx_data  in  8  received byte.
data_needed  in  1  one-cycle strobe; the slave latches tx_data on this cycle.
tx_data  out  8  next byte to shift out.
hex_flat  out  4*NUM_DIGITS  digit nibbles; digit i occupies bits [4i+3:4i].
dp_flat  out  NUM_DIGITS  decimal points; bit i belongs to digit i.
err_count  out  8  count of protocol errors; saturates at 255.
frame_done  out  1  one-cycle pulse when a command completes normally.

Behaviour:
- Reset (rst_n low at a clock edge):
  - hex_flat = all RESET_HEX, dp_flat = 0, err_count = 0, frame_done = 0.
  - tx_data = ID_BYTE, state = IDLE.
- Command byte layout:
  - [7:6] opcode: 00 NOP, 01 WRITE, 10 READ, 11 WRITE_ALL.
  - [5:3] reserved.
  - [2:0] digit index.
- Data byte layout: [3:0] hex, [4] dp, [7:5] ignored.
- States: IDLE, WR_DATA, WRALL_DATA, DISCARD.
- IDLE, on byte_rx:
  - NOP: stay in IDLE, pulse frame_done.
  - WRITE with idx < NUM_DIGITS: latch idx, go to WR_DATA.
  - READ with idx < NUM_DIGITS: tx_data <= {3'b0, dp[idx], hex[idx]}, pulse frame_done, stay in IDLE.
  - WRITE_ALL: idx field ignored, pointer <= 0, go to WRALL_DATA.
  - WRITE/READ with idx >= NUM_DIGITS: err_count++, tx_data <= ID_BYTE, go to DISCARD.
- WR_DATA, on byte_rx: write digit idx, pulse frame_done, return to IDLE.
- WRALL_DATA, on byte_rx:
  - Write digit[pointer], pointer++.
  - At pointer == NUM_DIGITS-1: write, pulse frame_done, go to IDLE.
- DISCARD: ignore all bytes until ssel goes high.
- Frame boundary:
  - ssel high in any state forces IDLE next cycle.
  - In WR_DATA or WRALL_DATA, ssel high is an aborted frame and increments err_count. Digits already written by WRITE_ALL stay written (no rollback).
  - ssel high has priority over a byte_rx in the same cycle; that byte is dropped and not counted as an error.
- Latency: register writes and tx_data updates become visible on the clock edge after the byte_rx cycle.
- data_needed: tx_data holds its value across data_needed. After data_needed, tx_data reverts to ID_BYTE unless a READ loads it in the same cycle; in that case the READ value wins.
- Reset mid-frame: rst_n low overrides everything; state returns to IDLE and registers clear.
- err_count saturates at 8'hFF and never wraps.
- hex_flat and dp_flat change only on writes.

Decomposition:
- Shared package holds:
  - opcode constants (OP_NOP, OP_WRITE, OP_READ, OP_WRALL);
  - state encoding;
  - bit-field positions for the command and data bytes;
  - ID_BYTE default.
- One natural sub-module: disp_digit_regfile. It holds the NUM_DIGITS x 5-bit storage with one write port (we, waddr, wdata), one read port for readback, and flat outputs. The parser FSM stays in the top module.

Test Plan:
- Reset: rst_n low 2 cycles -> hex_flat = 0, dp_flat = 0, err_count = 0, tx_data = 8'hA5.
- Single write: frame [0x43, 0x1B] -> digit3 = 0xB, dp3 = 1, other digits unchanged, frame_done pulses once, one cycle after the second byte_rx.
- Bulk write then read: [0xC0, 0x01, 0x02, 0x03, 0x04, 0x05, 0x16], ssel high, then [0x85] -> hex_flat = 24'h654321, dp_flat = 6'b100000, tx_data = 8'h16 before the next data_needed.
- Bad index: [0x47, 0x09] -> err_count = 1, no register change, byte 0x09 ignored, tx_data = 8'hA5.
- Aborted WRITE_ALL: [0xC0, 0x0A, 0x0B], ssel high -> digit0 = 0xA, digit1 = 0xB, digits 2-5 unchanged, err_count = 1, next frame [0x40, 0x0C] writes digit0 = 0xC.
- Collisions: ssel high in the same cycle as byte_rx -> byte dropped, state = IDLE. Force 256 errors -> err_count holds at 255.

Source files
------------

// File: rtl/disp_spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder: opcodes, FSM states,
// command/data byte field positions and the digit payload type.
package disp_spi_cmd_decoder_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned HEX_W       = 4;
    localparam int unsigned IDX_W       = 3;

    localparam int unsigned CMD_OP_MSB  = 7;
    localparam int unsigned CMD_OP_LSB  = 6;
    localparam int unsigned CMD_IDX_MSB = 2;
    localparam int unsigned CMD_IDX_LSB = 0;
    localparam int unsigned DATA_HEX_MSB = 3;
    localparam int unsigned DATA_HEX_LSB = 0;
    localparam int unsigned DATA_DP_BIT  = 4;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRALL = 2'b11;

    localparam logic [BYTE_W-1:0] ID_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WRALL_DATA,
        ST_DISCARD
    } state_e;

    typedef struct packed {
        logic             dp;
        logic [HEX_W-1:0] hex;
    } digit_t;

    function automatic digit_t data_to_digit(input logic [BYTE_W-1:0] b);
        digit_t d;
        d.dp  = b[DATA_DP_BIT];
        d.hex = b[DATA_HEX_MSB:DATA_HEX_LSB];
        return d;
    endfunction

endpackage

// File: rtl/disp_spi_cmd_decoder_regfile.sv
// Digit register file: NUM_DIGITS x {dp, hex}, one write port, one
// combinational read port for readback, and flattened outputs for the mux.
module disp_digit_regfile
    import disp_spi_cmd_decoder_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter logic [3:0]  RESET_HEX  = 4'h0
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        waddr_i,
    input  digit_t                  wdata_i,
    input  logic [IDX_W-1:0]        raddr_i,
    output digit_t                  rdata_c_o,
    output logic [4*NUM_DIGITS-1:0] hex_flat_o,
    output logic [NUM_DIGITS-1:0]   dp_flat_o
);

    digit_t mem_q [NUM_DIGITS];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                mem_q[i] <= '{dp: 1'b0, hex: RESET_HEX};
            end
        end else if (we_i && (32'(waddr_i) < NUM_DIGITS)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Out-of-range read addresses return zero rather than indexing past the array.
    always_comb begin
        rdata_c_o = '0;
        if (32'(raddr_i) < NUM_DIGITS) begin
            rdata_c_o = mem_q[raddr_i];
        end
    end

    always_comb begin
        hex_flat_o = '0;
        dp_flat_o  = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            hex_flat_o[4*i +: 4] = mem_q[i].hex;
            dp_flat_o[i]         = mem_q[i].dp;
        end
    end

endmodule

// File: rtl/disp_spi_cmd_decoder.sv
// Framed SPI command parser feeding the 6-digit hex display register file,
// with readback via tx_data and a saturating protocol-error counter.
module disp_spi_cmd_decoder
    import disp_spi_cmd_decoder_pkg::*;
#(
    parameter int unsigned       NUM_DIGITS = 6,
    parameter logic [BYTE_W-1:0] ID_BYTE    = ID_BYTE_DEFAULT,
    parameter logic [HEX_W-1:0]  RESET_HEX  = 4'h0
) (
    input  logic                    CLK_12_MHZ,
    input  logic                    rst_n,
    input  logic                    ssel,
    input  logic                    byte_rx,
    input  logic [BYTE_W-1:0]       rx_data,
    input  logic                    data_needed,
    output logic [BYTE_W-1:0]       tx_data,
    output logic [4*NUM_DIGITS-1:0] hex_flat,
    output logic [NUM_DIGITS-1:0]   dp_flat,
    output logic [7:0]              err_count,
    output logic                    frame_done
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic [7:0]         err_count_q, err_count_d;
    logic               frame_done_q, frame_done_d;

    logic               we_c;
    logic [IDX_W-1:0]   waddr_c;
    digit_t             rdata_c;
    logic               err_inc_c;
    logic [1:0]         cmd_op_c;
    logic [IDX_W-1:0]   cmd_idx_c;
    logic               idx_ok_c;
    logic               unused_rsvd_c;

    assign cmd_op_c      = rx_data[CMD_OP_MSB:CMD_OP_LSB];
    assign cmd_idx_c     = rx_data[CMD_IDX_MSB:CMD_IDX_LSB];
    assign idx_ok_c      = 32'(cmd_idx_c) < NUM_DIGITS;
    assign unused_rsvd_c = rx_data[5];

    disp_digit_regfile #(
        .NUM_DIGITS (NUM_DIGITS),
        .RESET_HEX  (RESET_HEX)
    ) u_regfile (
        .clk_i      (CLK_12_MHZ),
        .rst_n_i    (rst_n),
        .we_i       (we_c),
        .waddr_i    (waddr_c),
        .wdata_i    (data_to_digit(rx_data)),
        .raddr_i    (cmd_idx_c),
        .rdata_c_o  (rdata_c),
        .hex_flat_o (hex_flat),
        .dp_flat_o  (dp_flat)
    );

    always_ff @(posedge CLK_12_MHZ) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            ptr_q        <= '0;
            tx_data_q    <= ID_BYTE;
            err_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            tx_data_q    <= tx_data_d;
            err_count_q  <= err_count_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Parser: ssel high ends the frame and wins over a same-cycle byte.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        tx_data_d    = tx_data_q;
        err_count_d  = err_count_q;
        frame_done_d = 1'b0;
        we_c         = 1'b0;
        waddr_c      = idx_q;
        err_inc_c    = 1'b0;

        if (data_needed) begin
            tx_data_d = ID_BYTE;
        end

        if (ssel) begin
            state_d   = ST_IDLE;
            err_inc_c = (state_q == ST_WR_DATA) || (state_q == ST_WRALL_DATA);
        end else if (byte_rx) begin
            case (state_q)
                ST_IDLE: begin
                    case (cmd_op_c)
                        OP_NOP: frame_done_d = 1'b1;
                        OP_WRITE: begin
                            if (idx_ok_c) begin
                                idx_d   = cmd_idx_c;
                                state_d = ST_WR_DATA;
                            end else begin
                                err_inc_c = 1'b1;
                                tx_data_d = ID_BYTE;
                                state_d   = ST_DISCARD;
                            end
                        end
                        OP_READ: begin
                            if (idx_ok_c) begin
                                tx_data_d    = {3'b000, rdata_c};
                                frame_done_d = 1'b1;
                            end else begin
                                err_inc_c = 1'b1;
                                tx_data_d = ID_BYTE;
                                state_d   = ST_DISCARD;
                            end
                        end
                        default: begin
                            ptr_d   = '0;
                            state_d = ST_WRALL_DATA;
                        end
                    endcase
                end
                ST_WR_DATA: begin
                    we_c         = 1'b1;
                    waddr_c      = idx_q;
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
                ST_WRALL_DATA: begin
                    we_c    = 1'b1;
                    waddr_c = ptr_q;
                    if (ptr_q == IDX_W'(NUM_DIGITS - 1)) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end

        if (err_inc_c && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    assign tx_data    = tx_data_q;
    assign err_count  = err_count_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_spi_cmd_decoder.sv
// Bench for disp_spi_cmd_decoder: frame-level stimulus, a reference model of
// the digit file, and a scoreboard of expected results at each frame_done.
`timescale 1ns/1ps
module tb_disp_spi_cmd_decoder;

    localparam int unsigned ND = 6;

    logic          clk = 1'b0;
    logic          rst_n, ssel, byte_rx, data_needed;
    logic [7:0]    rx_data;
    logic [7:0]    tx_data;
    logic [4*ND-1:0] hex_flat;
    logic [ND-1:0] dp_flat;
    logic [7:0]    err_count;
    logic          frame_done;

    always #42 clk = ~clk;

    disp_spi_cmd_decoder dut (
        .CLK_12_MHZ  (clk),
        .rst_n       (rst_n),
        .ssel        (ssel),
        .byte_rx     (byte_rx),
        .rx_data     (rx_data),
        .data_needed (data_needed),
        .tx_data     (tx_data),
        .hex_flat    (hex_flat),
        .dp_flat     (dp_flat),
        .err_count   (err_count),
        .frame_done  (frame_done)
    );

    typedef struct {
        logic [4*ND-1:0] hex;
        logic [ND-1:0]   dp;
        logic [7:0]      tx;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] m_hex [ND];
    logic       m_dp  [ND];
    logic [7:0] m_err;
    logic [7:0] m_tx;

    function automatic logic [4*ND-1:0] model_hex();
        logic [4*ND-1:0] v = '0;
        for (int i = 0; i < int'(ND); i++) v[4*i +: 4] = m_hex[i];
        return v;
    endfunction

    function automatic logic [ND-1:0] model_dp();
        logic [ND-1:0] v = '0;
        for (int i = 0; i < int'(ND); i++) v[i] = m_dp[i];
        return v;
    endfunction

    function automatic logic [45:0] model_snap();
        return {model_hex(), model_dp(), m_err, m_tx};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(ND); i++) begin
            m_hex[i] = 4'h0;
            m_dp[i]  = 1'b0;
        end
        m_err = 8'd0;
        m_tx  = 8'hA5;
    endtask

    task automatic m_write(input int i, input logic [7:0] b);
        m_hex[i] = b[3:0];
        m_dp[i]  = b[4];
    endtask

    task automatic push_exp();
        exp_t e;
        e.hex = model_hex();
        e.dp  = model_dp();
        e.tx  = m_tx;
        sb.push_back(e);
    endtask

    task automatic start_frame();
        @(negedge clk);
        ssel = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk);
        ssel = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_rx = 1'b1;
        rx_data = b;
        @(negedge clk);
        byte_rx = 1'b0;
        rx_data = 8'h00;
    endtask

    // Every frame_done pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_done === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: frame_done got 1 required 0 (no pending result)");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({hex_flat, dp_flat, tx_data} !== {e.hex, e.dp, e.tx}) begin
                    n_fail++;
                    $display("FAIL sb_done: hex/dp/tx got %h/%b/%h required %h/%b/%h",
                             hex_flat, dp_flat, tx_data, e.hex, e.dp, e.tx);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; ssel = 1'b1; byte_rx = 1'b0; data_needed = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        model_reset();
        n_tests++;
        if ({hex_flat, dp_flat, err_count, tx_data, frame_done} !== {model_snap(), 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got %h/%b/%h/%h/%b required %h/%b/%h/%h/0",
                     hex_flat, dp_flat, err_count, tx_data, frame_done,
                     model_hex(), model_dp(), m_err, m_tx);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        start_frame();
        send_byte(8'h43);
        n_tests++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_cmd_done: frame_done got %b required 0", frame_done);
        end
        m_write(3, 8'h1B);
        push_exp();
        send_byte(8'h1B);
        n_tests++;
        if ({frame_done, model_snap()} !== {frame_done, hex_flat, dp_flat, err_count, tx_data} || frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL single_write: done/hex/dp got %b/%h/%b required 1/%h/%b",
                     frame_done, hex_flat, dp_flat, model_hex(), model_dp());
        end
        @(negedge clk);
        n_tests++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: frame_done got %b required 0", frame_done);
        end
        end_frame();
    endtask

    task automatic test_bulk_read();
        logic [7:0] b;
        start_frame();
        send_byte(8'hC0);
        for (int i = 0; i < int'(ND); i++) begin
            b = (i == int'(ND) - 1) ? 8'h16 : 8'(i + 1);
            m_write(i, b);
            if (i == int'(ND) - 1) push_exp();
            send_byte(b);
        end
        end_frame();
        n_tests++;
        if ({hex_flat, dp_flat} !== {24'h654321, 6'b100000}) begin
            n_fail++;
            $display("FAIL bulk_write: hex/dp got %h/%b required 654321/100000", hex_flat, dp_flat);
        end
        start_frame();
        m_tx = 8'h16;
        push_exp();
        send_byte(8'h85);
        repeat (3) @(negedge clk);
        @(negedge clk);
        data_needed = 1'b1;
        #1;
        n_tests++;
        if (tx_data !== 8'h16) begin
            n_fail++;
            $display("FAIL read_hold: tx_data got %h required 16", tx_data);
        end
        @(negedge clk);
        data_needed = 1'b0;
        m_tx = 8'hA5;
        n_tests++;
        if (tx_data !== m_tx) begin
            n_fail++;
            $display("FAIL read_revert: tx_data got %h required %h", tx_data, m_tx);
        end
        m_tx = {3'b000, m_dp[2], m_hex[2]};
        push_exp();
        @(negedge clk);
        byte_rx = 1'b1; rx_data = 8'h82; data_needed = 1'b1;
        @(negedge clk);
        byte_rx = 1'b0; rx_data = 8'h00; data_needed = 1'b0;
        n_tests++;
        if (tx_data !== 8'h03) begin
            n_fail++;
            $display("FAIL read_vs_needed: tx_data got %h required 03", tx_data);
        end
        end_frame();
    endtask

    task automatic test_bad_index();
        start_frame();
        send_byte(8'h47);
        m_err = m_err + 8'd1;
        m_tx  = 8'hA5;
        send_byte(8'h09);
        end_frame();
        n_tests++;
        if ({hex_flat, dp_flat, err_count, tx_data} !== model_snap()) begin
            n_fail++;
            $display("FAIL bad_write_idx: got %h/%b/%h/%h required %h/%b/%h/%h",
                     hex_flat, dp_flat, err_count, tx_data, model_hex(), model_dp(), m_err, m_tx);
        end
        start_frame();
        m_tx = {3'b000, m_dp[0], m_hex[0]};
        push_exp();
        send_byte(8'h80);
        send_byte(8'h86);
        m_err = m_err + 8'd1;
        m_tx  = 8'hA5;
        end_frame();
        n_tests++;
        if ({hex_flat, dp_flat, err_count, tx_data} !== model_snap()) begin
            n_fail++;
            $display("FAIL bad_read_idx: got %h/%b/%h/%h required %h/%b/%h/%h",
                     hex_flat, dp_flat, err_count, tx_data, model_hex(), model_dp(), m_err, m_tx);
        end
    endtask

    task automatic test_abort_wrall();
        start_frame();
        send_byte(8'hC0);
        send_byte(8'h0A); m_write(0, 8'h0A);
        send_byte(8'h0B); m_write(1, 8'h0B);
        end_frame();
        m_err = m_err + 8'd1;
        n_tests++;
        if ({hex_flat, dp_flat, err_count, tx_data} !== model_snap()) begin
            n_fail++;
            $display("FAIL abort_wrall: got %h/%b/%h/%h required %h/%b/%h/%h",
                     hex_flat, dp_flat, err_count, tx_data, model_hex(), model_dp(), m_err, m_tx);
        end
        start_frame();
        send_byte(8'h40);
        m_write(0, 8'h0C);
        push_exp();
        send_byte(8'h0C);
        end_frame();
        n_tests++;
        if ({hex_flat, dp_flat, err_count, tx_data} !== model_snap()) begin
            n_fail++;
            $display("FAIL after_abort_write: got %h/%b/%h required %h/%b/%h",
                     hex_flat, dp_flat, err_count, model_hex(), model_dp(), m_err);
        end
    endtask

    task automatic test_collision();
        start_frame();
        @(negedge clk);
        ssel = 1'b1; byte_rx = 1'b1; rx_data = 8'h43;
        @(negedge clk);
        byte_rx = 1'b0; rx_data = 8'h00;
        start_frame();
        push_exp();
        send_byte(8'h1B);
        end_frame();
        n_tests++;
        if ({hex_flat, dp_flat, err_count, tx_data} !== model_snap()) begin
            n_fail++;
            $display("FAIL collide_idle: got %h/%b/%h/%h required %h/%b/%h/%h",
                     hex_flat, dp_flat, err_count, tx_data, model_hex(), model_dp(), m_err, m_tx);
        end
        start_frame();
        send_byte(8'h43);
        @(negedge clk);
        ssel = 1'b1; byte_rx = 1'b1; rx_data = 8'h1F;
        @(negedge clk);
        byte_rx = 1'b0; rx_data = 8'h00;
        m_err = m_err + 8'd1;
        n_tests++;
        if ({hex_flat, dp_flat, err_count, tx_data} !== model_snap()) begin
            n_fail++;
            $display("FAIL collide_wr: got %h/%b/%h/%h required %h/%b/%h/%h",
                     hex_flat, dp_flat, err_count, tx_data, model_hex(), model_dp(), m_err, m_tx);
        end
        start_frame();
        m_tx = {3'b000, m_dp[3], m_hex[3]};
        push_exp();
        send_byte(8'h83);
        end_frame();
        n_tests++;
        if (tx_data !== m_tx) begin
            n_fail++;
            $display("FAIL collide_then_read: tx_data got %h required %h", tx_data, m_tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        start_frame();
        @(negedge clk);
        byte_rx = 1'b1; rx_data = 8'hC0;
        for (int i = 0; i < int'(ND); i++) begin
            b = 8'hE0 | 8'((i & 1) << 4) | 8'(9 + i);
            m_write(i, b);
            if (i == int'(ND) - 1) push_exp();
            @(negedge clk);
            rx_data = b;
        end
        @(negedge clk);
        byte_rx = 1'b0; rx_data = 8'h00;
        end_frame();
        n_tests++;
        if ({hex_flat, dp_flat, err_count} !== {model_hex(), model_dp(), m_err}) begin
            n_fail++;
            $display("FAIL back_to_back: got %h/%b/%h required %h/%b/%h",
                     hex_flat, dp_flat, err_count, model_hex(), model_dp(), m_err);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 260; k++) begin
            start_frame();
            send_byte(8'h47);
            end_frame();
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
        m_tx = 8'hA5;
        n_tests++;
        if (err_count !== 8'hFF || {hex_flat, dp_flat, err_count, tx_data} !== model_snap()) begin
            n_fail++;
            $display("FAIL err_saturate: err_count got %h required ff (tx %h)", err_count, tx_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        start_frame();
        send_byte(8'hC0);
        send_byte(8'h07);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        n_tests++;
        if ({hex_flat, dp_flat, err_count, tx_data, frame_done} !== {model_snap(), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got %h/%b/%h/%h required %h/%b/%h/%h",
                     hex_flat, dp_flat, err_count, tx_data, model_hex(), model_dp(), m_err, m_tx);
        end
        send_byte(8'h44);
        m_write(4, 8'h0D);
        push_exp();
        send_byte(8'h0D);
        end_frame();
        n_tests++;
        if ({hex_flat, dp_flat, err_count, tx_data} !== model_snap()) begin
            n_fail++;
            $display("FAIL post_reset_write: got %h/%b/%h required %h/%b/%h",
                     hex_flat, dp_flat, err_count, model_hex(), model_dp(), m_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_bulk_read();
        test_bad_index();
        test_abort_wrall();
        test_collision();
        test_back_to_back();
        test_saturation();
        test_reset_mid_frame();
        repeat (2) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: pending results got %0d required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
